// File: rtl/hc_gate_array_pkg.sv
// rtl/hc_gate_array_pkg.sv - function codes and gate evaluation helpers
//
// Shared definitions for the configurable gate array:
//   hc_func_e    3-bit function code held per channel (HC_NOR..HC_INV)
//   cfg_state_e  state of the config write handshake
//   gate_eval()  combinational result of one 2-input gate for a given code
//   reset_y()    output value a channel shows while its inputs are all 0
//   chan_w()     width of the channel-select field for a given channel count
package hc_gate_array_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    HC_NOR  = 3'd0,
    HC_NAND = 3'd1,
    HC_AND  = 3'd2,
    HC_OR   = 3'd3,
    HC_XOR  = 3'd4,
    HC_XNOR = 3'd5,
    HC_BUF  = 3'd6,
    HC_INV  = 3'd7
  } hc_func_e;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_BUSY = 1'b1
  } cfg_state_e;

  // BUF and INV look at A only; B is ignored for those codes.
  function automatic logic gate_eval(hc_func_e f, logic a, logic b);
    logic r;
    r = ~(a | b);
    case (f)
      HC_NOR:  r = ~(a | b);
      HC_NAND: r = ~(a & b);
      HC_AND:  r = a & b;
      HC_OR:   r = a | b;
      HC_XOR:  r = a ^ b;
      HC_XNOR: r = ~(a ^ b);
      HC_BUF:  r = a;
      HC_INV:  r = ~a;
    endcase
    return r;
  endfunction

  // Synchronisers clear to 0 at reset, so Y must start at f(code,0,0)
  // to avoid a spurious transition right after reset release.
  function automatic logic reset_y(logic [FUNC_W-1:0] code);
    return gate_eval(hc_func_e'(code), 1'b0, 1'b0);
  endfunction

  function automatic int chan_w(int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/hc_gate_array_if.sv
// rtl/hc_gate_array_if.sv - config write channel of the gate array
//
// Request/accept handshake used to change one channel's function code.
//   cfg_valid  master -> slave  write request, held until accepted
//   cfg_ready  slave -> master  request accepted on a cycle with valid && ready
//   cfg_chan   master -> slave  target channel, chan_w(CH) bits
//   cfg_func   master -> slave  new function code (hc_func_e encoding)
//   cfg_err    slave -> master  one-cycle pulse after a write to a channel >= CH
interface hc_gate_array_if #(
  parameter int CH = 4
);
  import hc_gate_array_pkg::*;

  localparam int CHAN_W = chan_w(CH);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [FUNC_W-1:0] cfg_func;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_func,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_func,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/hc_gate_array_chan.sv
// rtl/hc_gate_array_chan.sv - one gate channel: synchronisers, function reg, glitch filter
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   a, b        raw pad inputs, asynchronous to clk
//   cfg_we      one-cycle strobe: load cfg_func into this channel
//   cfg_func    function code to load
//   y           filtered, registered gate output
//
// The candidate result must differ from y for FILT_LEN consecutive edges
// before y follows it; any edge where they agree restarts the count.
module hc_gate_array_chan
  import hc_gate_array_pkg::*;
#(
  parameter int                SYNC_STAGES  = 2,
  parameter int                FILT_LEN     = 1,
  parameter logic [FUNC_W-1:0] DEFAULT_FUNC = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              cfg_we,
  input  logic [FUNC_W-1:0] cfg_func,
  output logic              y
);

  localparam int               CNT_W    = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  hc_func_e               func;
  logic [CNT_W-1:0]       cnt;
  logic                   cand;

  assign cand = gate_eval(func, a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      func   <= hc_func_e'(DEFAULT_FUNC);
      cnt    <= '0;
      y      <= reset_y(DEFAULT_FUNC);
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};

      // A function write restarts the filter: the candidate from the new
      // function must then survive a full FILT_LEN window on its own.
      if (cfg_we) begin
        func <= hc_func_e'(cfg_func);
        cnt  <= '0;
      end else if (cand == y) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        y   <= cand;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hc_gate_array.sv
// rtl/hc_gate_array.sv - array of CH configurable 2-input gates with glitch filters
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (released synchronously)
//   A, B        CH-bit raw gate inputs, asynchronous to clk
//   cfg         config write channel (slave side), see hc_gate_array_if
//   Y           CH-bit filtered, registered gate outputs
//
// Every channel powers up with DEFAULT_FUNC (NOR by default, matching a
// 74HC02). The top holds the config handshake: an accepted write to a valid
// channel costs one busy cycle; a write to a channel >= CH is acknowledged
// without a busy cycle, changes nothing and pulses cfg_err.
module hc_gate_array
  import hc_gate_array_pkg::*;
#(
  parameter int                CH           = 4,
  parameter int                SYNC_STAGES  = 2,
  parameter int                FILT_LEN     = 1,
  parameter logic [FUNC_W-1:0] DEFAULT_FUNC = 3'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] A,
  input  logic [CH-1:0] B,
  hc_gate_array_if.slave cfg,
  output logic [CH-1:0] Y
);

  cfg_state_e    state;
  cfg_state_e    state_nxt;
  logic          accept;
  logic          chan_ok;
  logic          err_nxt;
  logic          err_q;
  logic [CH-1:0] chan_we;

  assign cfg.cfg_ready = (state == CFG_IDLE);
  assign cfg.cfg_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CFG_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Channel number compared at 32 bits so a non-power-of-two CH leaves
  // the top codes of cfg_chan reachable and flagged as errors.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    chan_we   = '0;
    accept    = cfg.cfg_valid && (state == CFG_IDLE);
    chan_ok   = (32'(cfg.cfg_chan) < 32'(CH));
    case (state)
      CFG_IDLE: begin
        if (accept) begin
          if (chan_ok) begin
            state_nxt = CFG_BUSY;
            for (int i = 0; i < CH; i++) begin
              chan_we[i] = (32'(cfg.cfg_chan) == 32'(i));
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CFG_BUSY: begin
        state_nxt = CFG_IDLE;
      end
      default: begin
        state_nxt = CFG_IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    hc_gate_array_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILT_LEN     (FILT_LEN),
      .DEFAULT_FUNC (DEFAULT_FUNC)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (A[g]),
      .b        (B[g]),
      .cfg_we   (chan_we[g]),
      .cfg_func (cfg.cfg_func),
      .y        (Y[g])
    );
  end

endmodule

// File: tb/tb_hc_gate_array.sv
// tb/tb_hc_gate_array.sv - self-checking bench for hc_gate_array
//
// dut0: default parameters (CH=4, FILT_LEN=1), directed latency/config cases.
// dut1: CH=6, FILT_LEN=4, tracked every cycle by a behavioural model and
//       driven with directed pulses, invalid-channel writes, a mid-filter
//       reset and a randomised run.
module tb_hc_gate_array;
  import hc_gate_array_pkg::*;

  localparam int CH1 = 6;
  localparam int S1  = 2;
  localparam int F1  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]     a0, b0, y0;
  logic [CH1-1:0] a1, b1, y1;

  hc_gate_array_if #(.CH(4))   cfg0 ();
  hc_gate_array_if #(.CH(CH1)) cfg1 ();

  hc_gate_array u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a0),
    .B     (b0),
    .cfg   (cfg0),
    .Y     (y0)
  );

  hc_gate_array #(
    .CH          (CH1),
    .SYNC_STAGES (S1),
    .FILT_LEN    (F1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a1),
    .B     (b1),
    .cfg   (cfg1),
    .Y     (y1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of dut1: pad history arrays stand in for the
  // synchronisers, run[] counts consecutive disagreeing edges per channel.
  logic [CH1-1:0] m_ah [S1];
  logic [CH1-1:0] m_bh [S1];
  int             m_func [CH1];
  int             m_run  [CH1];
  logic [CH1-1:0] m_y;
  bit             m_ready;
  bit             m_err;
  bit             m_acc;

  function automatic bit ref_gate(int code, bit a, bit b);
    int s;
    s = int'(a) + int'(b);
    case (code)
      0: return s == 0;
      1: return s != 2;
      2: return s == 2;
      3: return s != 0;
      4: return s == 1;
      5: return s != 1;
      6: return a;
      default: return !a;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S1; k++) begin
      m_ah[k] = '0;
      m_bh[k] = '0;
    end
    for (int i = 0; i < CH1; i++) begin
      m_func[i] = 0;
      m_run[i]  = 0;
    end
    m_y     = '1;
    m_ready = 1'b1;
    m_err   = 1'b0;
    m_acc   = 1'b0;
  endtask

  task automatic model_step();
    int  chan;
    bit  wr;
    bit  c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    chan  = int'(cfg1.cfg_chan);
    m_acc = cfg1.cfg_valid && m_ready;
    wr    = m_acc && (chan < CH1);
    for (int i = 0; i < CH1; i++) begin
      c = ref_gate(m_func[i], m_ah[S1-1][i], m_bh[S1-1][i]);
      if (wr && chan == i) begin
        m_run[i]  = 0;
        m_func[i] = int'(cfg1.cfg_func);
      end else if (c != m_y[i]) begin
        if (m_run[i] + 1 >= F1) begin
          m_y[i]   = c;
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_ready = !wr;
    m_err   = m_acc && (chan >= CH1);
    for (int k = S1 - 1; k > 0; k--) begin
      m_ah[k] = m_ah[k-1];
      m_bh[k] = m_bh[k-1];
    end
    m_ah[0] = a1;
    m_bh[0] = b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("y1_model", 32'(y1), 32'(m_y));
    check_eq("ready1_model", 32'(cfg1.cfg_ready), 32'(m_ready));
    check_eq("err1_model", 32'(cfg1.cfg_err), 32'(m_err));
  endtask

  initial begin
    int n_acc;
    int idx;

    rst_n = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    cfg0.cfg_valid = 1'b0; cfg0.cfg_chan = '0; cfg0.cfg_func = '0;
    cfg1.cfg_valid = 1'b0; cfg1.cfg_chan = '0; cfg1.cfg_func = '0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state and 3-edge pad-to-Y latency at default parameters
    check_eq("rst_y0", 32'(y0), 32'hf);
    check_eq("rst_ready0", 32'(cfg0.cfg_ready), 32'h1);
    check_eq("rst_err0", 32'(cfg0.cfg_err), 32'h0);
    check_eq("rst_y1", 32'(y1), 32'h3f);
    a0 = 4'b0010;
    tick(); check_eq("lat_e1", 32'(y0), 32'hf);
    tick(); check_eq("lat_e2", 32'(y0), 32'hf);
    tick(); check_eq("lat_e3", 32'(y0), 32'hd);

    // FILT_LEN=4: 3-cycle pulse filtered, 4-cycle pulse passes for 4 cycles
    a1[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) a1[2] = 1'b0;
      check_eq("pulse3_y2", 32'(y1[2]), 32'h1);
    end
    a1[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) a1[2] = 1'b0;
      check_eq("pulse4_y2", 32'(y1[2]), (k >= 6 && k <= 9) ? 32'h0 : 32'h1);
    end

    // XOR write on dut0 channel 0 with A=B=1
    a0 = 4'b0011; b0 = 4'b0001;
    repeat (3) tick();
    check_eq("pre_xor_y0", 32'(y0), 32'hc);
    cfg0.cfg_valid = 1'b1; cfg0.cfg_chan = 2'd0; cfg0.cfg_func = HC_XOR;
    check_eq("xor_ready_before", 32'(cfg0.cfg_ready), 32'h1);
    tick();
    check_eq("xor_busy", 32'(cfg0.cfg_ready), 32'h0);
    cfg0.cfg_valid = 1'b0;
    tick();
    check_eq("xor_ready_after", 32'(cfg0.cfg_ready), 32'h1);
    check_eq("xor_11_y0", 32'(y0[0]), 32'h0);
    b0 = 4'b0000;
    repeat (3) tick();
    check_eq("xor_10_y0", 32'(y0), 32'hd);
    cfg0.cfg_valid = 1'b1; cfg0.cfg_func = HC_XNOR;
    tick();
    cfg0.cfg_valid = 1'b0;
    check_eq("xnor_e1", 32'(y0[0]), 32'h1);
    tick();
    check_eq("xnor_e2", 32'(y0[0]), 32'h0);

    // valid held 4 cycles: ready 1,0,1,0 and exactly two writes accepted
    cfg0.cfg_valid = 1'b1; cfg0.cfg_chan = 2'd1; cfg0.cfg_func = HC_BUF;
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      check_eq("b2b_ready", 32'(cfg0.cfg_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (cfg0.cfg_ready) n_acc++;
      tick();
    end
    cfg0.cfg_valid = 1'b0;
    check_eq("b2b_count", 32'(n_acc), 32'd2);
    check_eq("buf_hi_y0", 32'(y0), 32'he);
    a0 = 4'b0001;
    repeat (3) tick();
    check_eq("buf_lo_y0", 32'(y0), 32'hc);

    // Writes to nonexistent channels on dut1
    for (int c = CH1; c < 8; c++) begin
      cfg1.cfg_valid = 1'b1; cfg1.cfg_chan = 3'(c); cfg1.cfg_func = HC_AND;
      tick();
      cfg1.cfg_valid = 1'b0;
      check_eq("bad_err_pulse", 32'(cfg1.cfg_err), 32'h1);
      check_eq("bad_ready", 32'(cfg1.cfg_ready), 32'h1);
      tick();
      check_eq("bad_err_clear", 32'(cfg1.cfg_err), 32'h0);
      check_eq("bad_y1", 32'(y1), 32'h3f);
    end

    // NAND write, then reset in the middle of a filter window
    a1 = 6'b100001;
    repeat (6) tick();
    check_eq("pre_nand_y1", 32'(y1), 32'h1e);
    cfg1.cfg_valid = 1'b1; cfg1.cfg_chan = 3'd0; cfg1.cfg_func = HC_NAND;
    tick();
    cfg1.cfg_valid = 1'b0;
    repeat (4) tick();
    check_eq("nand_y1", 32'(y1), 32'h1f);
    a1 = 6'b101001;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_y1", 32'(y1), 32'h3f);
    check_eq("async_rst_y0", 32'(y0), 32'hf);
    check_eq("async_rst_ready1", 32'(cfg1.cfg_ready), 32'h1);
    check_eq("async_rst_err1", 32'(cfg1.cfg_err), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_eq("post_rst_nor_y1", 32'(y1), 32'h16);

    // Randomised run on dut1 against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, CH1 - 1);
        a1[idx] = ~a1[idx];
      end
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, CH1 - 1);
        b1[idx] = ~b1[idx];
      end
      if (!cfg1.cfg_valid && $urandom_range(0, 5) == 0) begin
        cfg1.cfg_valid = 1'b1;
        cfg1.cfg_chan  = 3'($urandom_range(0, 7));
        cfg1.cfg_func  = 3'($urandom_range(0, 7));
      end
      tick();
      if (m_acc) cfg1.cfg_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
